// File: rtl/ram_arbiter.sv
// Time-slices one single-port synchronous RAM between the CPU and a video fetch unit.
// Video wins each decision point until its burst limit; the CPU is stalled via cpu_ce.
module ram_arbiter #(
   parameter int unsigned VID_BURST_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic        cpu_ce,
   output logic [7:0]  cpu_in,
   input  logic        vid_req,
   input  logic [15:0] vid_address,
   output logic        vid_ack,
   output logic [7:0]  vid_data,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CPU_A = 3'd1,
      CPU_D = 3'd2,
      VID_A = 3'd3,
      VID_D = 3'd4
   } state_t;

   localparam logic [3:0] BURST = 4'(VID_BURST_MAX);

   state_t     state;
   logic [3:0] vid_run;
   logic       sel_vid;
   logic       we_slot;

   // Slot flags are registered alongside the state so every output is a clean decode of it.
   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         vid_run <= '0;
         sel_vid <= 1'b0;
         we_slot <= 1'b0;
         cpu_ce  <= 1'b0;
         vid_ack <= 1'b0;
      end else begin
         case (state)
            IDLE, CPU_D, VID_D: begin
               cpu_ce  <= 1'b0;
               vid_ack <= 1'b0;
               if (vid_req && (vid_run < BURST)) begin
                  state   <= VID_A;
                  vid_run <= vid_run + 4'd1;
                  sel_vid <= 1'b1;
                  we_slot <= 1'b0;
               end else begin
                  state   <= CPU_A;
                  vid_run <= '0;
                  sel_vid <= 1'b0;
                  we_slot <= 1'b1;
               end
            end
            CPU_A: begin
               state   <= CPU_D;
               we_slot <= 1'b0;
               cpu_ce  <= 1'b1;
            end
            VID_A: begin
               state   <= VID_D;
               vid_ack <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               vid_run <= '0;
               sel_vid <= 1'b0;
               we_slot <= 1'b0;
               cpu_ce  <= 1'b0;
               vid_ack <= 1'b0;
            end
         endcase
      end
   end

   // Read data is broadcast to both masters; only cpu_ce / vid_ack qualify it.
   assign mem_address = sel_vid ? vid_address : cpu_address;
   assign mem_wdata   = cpu_out;
   assign mem_we      = we_slot & cpu_we;
   assign cpu_in      = mem_rdata;
   assign vid_data    = mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: slot-level behavioural model with a shadow memory, checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ram_arbiter;

   localparam int BURST = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cpu_address, vid_address, mem_address;
   logic [7:0]  cpu_out, cpu_in, vid_data, mem_wdata, mem_rdata;
   logic        cpu_we, cpu_ce, vid_req, vid_ack, mem_we;

   logic [7:0]  ram    [65536];
   logic [7:0]  shadow [65536];

   int n_checks = 0;
   int n_fail   = 0;
   int we_count = 0;

   ram_arbiter #(.VID_BURST_MAX(BURST)) dut (
      .clock(clock), .reset(reset),
      .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
      .cpu_ce(cpu_ce), .cpu_in(cpu_in),
      .vid_req(vid_req), .vid_address(vid_address), .vid_ack(vid_ack), .vid_data(vid_data),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Board RAM: synchronous, read data is the old contents at the previous address.
   always @(posedge clock) begin
      if (mem_we === 1'b1) ram[mem_address] <= mem_wdata;
      mem_rdata <= ram[mem_address];
   end

   always @(negedge clock) if (mem_we === 1'b1) we_count <= we_count + 1;

   // Slot-level model: each slot is two cycles owned by one master; a new owner is chosen
   // whenever the arbiter is idle or a slot has just finished its second cycle.
   typedef enum {K_NONE, K_IDLE, K_CPU, K_VID} kind_t;
   kind_t m_kind = K_NONE;
   bit    m_second = 1'b0;
   int    m_run = 0;
   bit    m_slot_we = 1'b0;

   always @(posedge clock) begin
      if (m_kind == K_CPU && !m_second) begin
         m_slot_we <= cpu_we;
         if (cpu_we) shadow[cpu_address] <= cpu_out;
      end
      if (reset) begin
         m_kind   <= K_IDLE;
         m_second <= 1'b0;
         m_run    <= 0;
      end else if (m_kind == K_IDLE || m_second) begin
         m_second <= 1'b0;
         if (vid_req && m_run < BURST) begin
            m_kind <= K_VID;
            m_run  <= m_run + 1;
         end else begin
            m_kind <= K_CPU;
            m_run  <= 0;
         end
      end else if (m_kind != K_NONE) begin
         m_second <= 1'b1;
      end
   end

   always @(negedge clock) begin
      if (m_kind != K_NONE) begin
         check("cpu_ce", 32'(cpu_ce), 32'(m_kind == K_CPU && m_second));
         check("vid_ack", 32'(vid_ack), 32'(m_kind == K_VID && m_second));
         check("mem_we", 32'(mem_we), 32'(m_kind == K_CPU && !m_second && cpu_we));
         check("mem_address", 32'(mem_address), 32'((m_kind == K_VID) ? vid_address : cpu_address));
         check("mem_wdata", 32'(mem_wdata), 32'(cpu_out));
         if (m_kind == K_CPU && m_second && !m_slot_we)
            check("cpu_in", 32'(cpu_in), 32'(shadow[cpu_address]));
         if (m_kind == K_VID && m_second)
            check("vid_data", 32'(vid_data), 32'(shadow[vid_address]));
      end
   end

   task automatic sample(input int n, output logic [31:0] ce_t, output logic [31:0] ack_t,
                         output logic [7:0] cd, output logic [7:0] vd,
                         output logic [15:0] addr0, output logic we0);
      ce_t = '0; ack_t = '0; cd = '0; vd = '0; addr0 = '0; we0 = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         ce_t  = {ce_t[30:0], cpu_ce};
         ack_t = {ack_t[30:0], vid_ack};
         if (cpu_ce && cd == 8'h00) cd = cpu_in;
         if (vid_ack) vd = vid_data;
         if (i == 0) begin
            addr0 = mem_address;
            we0   = mem_we;
         end
      end
   endtask

   // Emulates the stalled CPU: presents one access and holds it until cpu_ce is seen.
   task automatic cpu_access(input logic [15:0] addr, input logic we, input logic [7:0] data,
                             output logic [7:0] got);
      bit ok = 1'b0;
      got = '0;
      cpu_address = addr;
      cpu_we      = we;
      cpu_out     = data;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (cpu_ce) begin
            got = cpu_in;
            ok  = 1'b1;
            break;
         end
      end
      if (!ok) check("cpu_access_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ce_t, ack_t;
      logic [7:0]  cd, vd, got;
      logic [15:0] addr0;
      logic        we0;
      int          w0, first_ce, second_ce;
      bit          found;

      for (int i = 0; i < 65536; i++) begin
         ram[i]    = 8'(i) ^ 8'(i >> 8);
         shadow[i] = 8'(i) ^ 8'(i >> 8);
      end
      ram[16'hF800] = 8'hC3; shadow[16'hF800] = 8'hC3;
      ram[16'h76D0] = 8'h9E; shadow[16'h76D0] = 8'h9E;

      cpu_address = 16'hF800; cpu_out = 8'h00; cpu_we = 1'b0;
      vid_req = 1'b0; vid_address = 16'h0000;

      // Reset then CPU reads: ce pattern 0,0,1,0,1 starting in IDLE.
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      sample(5, ce_t, ack_t, cd, vd, addr0, we0);
      check("t1_ce_pattern", ce_t, 32'b00101);
      check("t1_no_ack", ack_t, 32'd0);
      check("t1_idle_addr", 32'(addr0), 32'h0000_F800);
      check("t1_cpu_in", 32'(cd), 32'h0000_00C3);
      @(posedge clock); #1;

      // CPU write then read-back.
      w0 = we_count;
      cpu_access(16'h1234, 1'b1, 8'h5A, got);
      check("t2_single_we", 32'(we_count - w0), 32'd1);
      cpu_access(16'h1234, 1'b0, 8'h00, got);
      check("t2_readback", 32'(got), 32'h0000_005A);

      // Held video request: 10-cycle frame of 4 acks and 1 ce.
      cpu_address = 16'hF800;
      vid_req = 1'b1; vid_address = 16'h0100;
      repeat (10) @(negedge clock);
      sample(20, ce_t, ack_t, cd, vd, addr0, we0);
      check("t3_ack_count", 32'($countones(ack_t)), 32'd8);
      check("t3_ce_count", 32'($countones(ce_t)), 32'd2);
      first_ce = -1; second_ce = -1;
      for (int i = 0; i < 20; i++) begin
         if (ce_t[i]) begin
            if (first_ce < 0) first_ce = i;
            else second_ce = i;
         end
      end
      check("t3_ce_gap", 32'(second_ce - first_ce), 32'd10);
      @(posedge clock); #1;
      vid_req = 1'b0;

      // Video request raised during CPU_A: CPU slot completes first.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (cpu_ce) found = 1'b1;
      end
      check("t4_find_cpu_d", 32'(found), 32'd1);
      @(posedge clock); #1;
      vid_req = 1'b1; vid_address = 16'h76D0;
      sample(4, ce_t, ack_t, cd, vd, addr0, we0);
      check("t4_ce_pattern", ce_t, 32'b0100);
      check("t4_ack_pattern", ack_t, 32'b0001);
      check("t4_vid_data", 32'(vd), 32'h0000_009E);
      @(posedge clock); #1;
      vid_req = 1'b0;
      cpu_access(16'hF800, 1'b0, 8'h00, got);
      check("t4_cpu_resumes", 32'(got), 32'h0000_00C3);

      // Pending CPU write lands before a video read of the same address.
      cpu_address = 16'h2000; cpu_out = 8'hA7; cpu_we = 1'b1;
      @(negedge clock);
      check("t5_we_in_cpu_a", 32'(mem_we), 32'd1);
      vid_req = 1'b1; vid_address = 16'h2000;
      sample(3, ce_t, ack_t, cd, vd, addr0, we0);
      check("t5_ce_pattern", ce_t, 32'b100);
      check("t5_ack_pattern", ack_t, 32'b001);
      check("t5_vid_new_value", 32'(vd), 32'h0000_00A7);
      @(posedge clock); #1;
      cpu_we = 1'b0; cpu_address = 16'hF800; vid_address = 16'h3000;

      // Reset pulsed in VID_A: no ack for the interrupted slot, held request acked after.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (mem_address == 16'h3000 && !vid_ack) found = 1'b1;
      end
      check("t6_find_vid_a", 32'(found), 32'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      sample(3, ce_t, ack_t, cd, vd, addr0, we0);
      check("t6_ack_pattern", ack_t, 32'b001);
      check("t6_ce_pattern", ce_t, 32'b000);
      check("t6_reset_addr", 32'(addr0), 32'h0000_F800);
      check("t6_reset_we", 32'(we0), 32'd0);
      check("t6_vid_data", 32'(vd), 32'h0000_0030);
      @(posedge clock); #1;
      vid_req = 1'b0;
      repeat (6) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
